// File: rtl/idct_odd_recon_if.sv
// Handshake bundle for idct_odd_recon: odd coefficients in, odd partial terms out.
// The slave modport is the reconstruction block; the master modport drives it.
interface idct_odd_recon_if #(
    parameter int IN_WIDTH  = 16,
    parameter int DIM       = 8,
    parameter int ACC_WIDTH = 24
);
    logic                        in_valid;
    logic                        in_ready;
    logic signed [IN_WIDTH-1:0]  in_coef [DIM/2];
    logic                        out_valid;
    logic                        out_ready;
    logic signed [ACC_WIDTH-1:0] out_val [DIM/2];
    logic                        busy;

    modport master (
        output in_valid, in_coef, out_ready,
        input  in_ready, out_valid, out_val, busy
    );

    modport slave (
        input  in_valid, in_coef, out_ready,
        output in_ready, out_valid, out_val, busy
    );
endinterface

// File: rtl/idct_odd_recon.sv
// IntIDCT odd-part reconstruction: O[j] = sum_k X[2k+1]*C[k][j], one coef per cycle.
// Optional macro IDCT_ODD_ROUND_EN rounds and shifts the output by SHIFT.
module idct_odd_recon #(
    parameter int IN_WIDTH  = 16,
    parameter int DIM       = 8,
    parameter int ACC_WIDTH = 24,
    parameter int SHIFT     = 7
) (
    input logic              HCLK,
    input logic              HRESETn,
    idct_odd_recon_if.slave  bus
);
    localparam int N  = DIM / 2;
    localparam int KW = (N > 2) ? 2 : 1;

    if (DIM != 4 && DIM != 8) begin : g_bad_dim
        $error("idct_odd_recon: DIM must be 4 or 8");
    end
    if (ACC_WIDTH < IN_WIDTH + 8) begin : g_bad_acc
        $error("idct_odd_recon: ACC_WIDTH must be >= IN_WIDTH+8");
    end
    if (SHIFT < 1 || SHIFT >= ACC_WIDTH) begin : g_bad_shift
        $error("idct_odd_recon: SHIFT out of range");
    end

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t                      state;
    logic [KW-1:0]               k;
    logic                        in_ready_q;
    logic                        out_valid_q;
    logic                        busy_q;
    logic signed [IN_WIDTH-1:0]  coef_reg [N];
    logic signed [ACC_WIDTH-1:0] acc      [N];
    logic signed [ACC_WIDTH-1:0] prod     [N];
    logic signed [IN_WIDTH-1:0]  cur;

    function automatic logic signed [7:0] cmat(input int kk, input int jj);
        logic signed [7:0] c;
        c = '0;
        if (DIM == 8) begin
            case (kk * 4 + jj)
                0:  c = 8'sd89;
                1:  c = 8'sd75;
                2:  c = 8'sd50;
                3:  c = 8'sd18;
                4:  c = 8'sd75;
                5:  c = -8'sd18;
                6:  c = -8'sd89;
                7:  c = -8'sd50;
                8:  c = 8'sd50;
                9:  c = -8'sd89;
                10: c = 8'sd18;
                11: c = 8'sd75;
                12: c = 8'sd18;
                13: c = -8'sd50;
                14: c = 8'sd75;
                15: c = -8'sd89;
                default: c = '0;
            endcase
        end else begin
            case (kk * 2 + jj)
                0: c = 8'sd83;
                1: c = 8'sd36;
                2: c = 8'sd36;
                3: c = -8'sd83;
                default: c = '0;
            endcase
        end
        return c;
    endfunction

    // One row of C per cycle, selected by the coefficient index k
    always_comb begin
        cur = coef_reg[k];
        for (int j = 0; j < N; j++) begin
            prod[j] = ACC_WIDTH'(cur) * ACC_WIDTH'(cmat(int'(k), j));
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state       <= IDLE;
            k           <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int j = 0; j < N; j++) begin
                acc[j]      <= '0;
                coef_reg[j] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (bus.in_valid && in_ready_q) begin
                        for (int j = 0; j < N; j++) begin
                            coef_reg[j] <= bus.in_coef[j];
                            acc[j]      <= '0;
                        end
                        k          <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= ACC;
                    end
                end
                ACC: begin
                    for (int j = 0; j < N; j++) begin
                        acc[j] <= acc[j] + prod[j];
                    end
                    k <= k + 1'b1;
                    if (k == KW'(N - 1)) begin
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;

`ifdef IDCT_ODD_ROUND_EN
    localparam logic signed [ACC_WIDTH:0] RND = (ACC_WIDTH+1)'(1) << (SHIFT - 1);

    logic signed [ACC_WIDTH:0] wide [N];
    logic signed [ACC_WIDTH:0] shr  [N];

    // One guard bit keeps the rounding add from wrapping at full scale
    always_comb begin
        for (int j = 0; j < N; j++) begin
            wide[j]        = {acc[j][ACC_WIDTH-1], acc[j]} + RND;
            shr[j]         = wide[j] >>> SHIFT;
            bus.out_val[j] = shr[j][ACC_WIDTH-1:0];
        end
    end
`else
    always_comb begin
        for (int j = 0; j < N; j++) begin
            bus.out_val[j] = acc[j];
        end
    end
`endif
endmodule
